mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM-stage data-memory access unit of the 5-stage MIPS pipeline.
- Sits between the EX/MEM register and the MEM/WB register.
- Takes the load/store command for the instruction in MEM and runs it over a req/ack data bus.
- Stalls the pipeline until the access completes, then presents the aligned and extended load data on ReadDataM, which MEM/WB latches.

Parameters:
- TIMEOUT, 16, max BUSY cycles waiting for mem_ack before aborting with a bus error (legal range 1..255).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- MemReadM  in  1  load in MEM stage
- MemWriteM  in  1  store in MEM stage
- MemSizeM  in  2  access size: 0 byte, 1 half, 2 word; 3 is illegal and is treated as word
- MemSignedM  in  1  sign-extend sub-word loads (1) or zero-extend (0)
- ALUOutM  in  32  byte address
- WriteDataM  in  32  store data, right-justified
- ReadDataM  out  32  load result to MEM/WB
- StallM  out  1  hold IF..MEM stages and bubble MEM/WB
- AdErrM  out  1  misaligned address, combinational
- BusErrM  out  1  access timed out; valid in DONE cycle only
- mem_req  out  1  bus request, registered
- mem_we  out  1  write enable, registered
- mem_addr  out  32  word address ({ALUOutM[31:2],2'b00}), registered
- mem_be  out  4  byte enables, registered
- mem_wdata  out  32  lane-replicated store data, registered
- mem_ack  in  1  bus completion, single-cycle pulse
- mem_rdata  in  32  read data, valid with mem_ack

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
  - Captured read data and timeout counter cleared.
  - Consequently ReadDataM=0, StallM=0 and BusErrM=0.
  - Asserting reset mid-access drops mem_req immediately; the abandoned access is not retried.
- Access request: acc = MemReadM | MemWriteM. With both high, the access is a write (write priority).
- Misalignment:
  - mis = (size half & addr[0]) | (size word & addr[1:0]!=0).
  - AdErrM = acc & mis, combinational, in any state.
  - A misaligned access issues no bus cycle, StallM=0, ReadDataM=0.
- State IDLE:
  - If acc & ~mis, StallM=1 combinationally.
  - Register mem_req=1, mem_we, mem_addr, mem_be and mem_wdata; go BUSY.
  - Otherwise stay in IDLE.
- State BUSY:
  - StallM=1; bus outputs held stable; timeout counter increments each cycle.
  - mem_ack=1: capture mem_rdata, mem_req<=0, go DONE.
  - Counter reaches TIMEOUT-1 with no ack: mem_req<=0, set error flag, go DONE.
- State DONE:
  - StallM=0, so the pipeline advances at this edge and MEM/WB latches ReadDataM.
  - BusErrM = error flag; the flag clears on leaving DONE.
  - Unconditionally return to IDLE, so the next instruction is evaluated fresh.
- Latency: a zero-wait bus (ack in the first BUSY cycle) costs 2 stall cycles. Each wait cycle adds 1.
- mem_ack outside BUSY is ignored (late ack after timeout).
- Store lanes (little-endian, lane = addr[1:0]):
  - byte: be=1<<lane, wdata={4{WD[7:0]}}.
  - half: be=3<<lane, wdata={2{WD[15:0]}}.
  - word: be=4'hF, wdata=WD.
- Load extraction:
  - Select the byte/half at the lane from the captured data.
  - Sign- or zero-extend per MemSignedM (registered with the request).
  - word: pass through. On a write or bus error, ReadDataM=0.
- Outside DONE, ReadDataM=0.

Decomposition:
- Shared package mem_pkg:
  - MEM_BYTE/MEM_HALF/MEM_WORD size constants.
  - State encoding IDLE/BUSY/DONE.
- Sub-module mem_load_align (combinational): captured word, lane, size and signed in; 32-bit extended result out.
- Store-lane generation stays inline.

Test Plan:
- Aligned word load, addr 0x100, ack in first BUSY cycle, rdata 0xDEADBEEF -> mem_req high 1 cycle, StallM high 2 cycles, DONE ReadDataM=0xDEADBEEF, BusErrM=0.
- Signed byte load, addr 0x203, rdata 0x80123456, then unsigned -> ReadDataM=0xFFFFFF80, then 0x00000080; mem_addr=0x200.
- Half store, addr 0x302, WD 0x0000ABCD, ack after 3 wait cycles -> mem_we=1, mem_be=4'b1100, mem_wdata=0xABCDABCD held stable 4 cycles; StallM high 5 cycles.
- Word load at 0x102 -> AdErrM=1, StallM=0, mem_req never asserted, ReadDataM=0.
- No ack, TIMEOUT=16 -> mem_req high exactly 16 cycles, then DONE with BusErrM=1, ReadDataM=0; an ack on the following cycle is ignored and the state stays IDLE.
- rst_n pulsed low during BUSY -> mem_req, StallM and the error flag drop immediately, state IDLE; the next load completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage data-memory access unit.
//   - access size codes as carried on MemSizeM
//   - access FSM state encoding
//   - load context captured with each request and used to align the reply
package mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;  // 2'd3 is illegal and behaves as word

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } memState_t;

    // Everything the load aligner needs once the address inputs have moved on.
    typedef struct packed {
        logic [1:0] lane;
        logic [1:0] size;
        logic       sgn;
    } loadCtx_t;

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: extracts the byte/half/word addressed by a load from the
// captured 32-bit bus word and sign- or zero-extends it (little-endian lanes).
// Ports:
//   word   in  32  captured read data
//   lane   in  2   byte offset within the word
//   size   in  2   MEM_BYTE / MEM_HALF / word (3 treated as word)
//   sgn    in  1   sign-extend sub-word results when set
//   result out 32  extended load result
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] result
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = word[{lane, 3'b000} +: 8];
        // Halves are always aligned by the time they get here, so lane[1] picks.
        halfSel = lane[1] ? word[31:16] : word[15:0];
        case (size)
            MEM_BYTE: result = {{24{sgn & byteSel[7]}}, byteSel};
            MEM_HALF: result = {{16{sgn & halfSel[15]}}, halfSel};
            default:  result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage data-memory access unit. Runs the load/store of
// the instruction in MEM over a req/ack bus, stalls the pipeline until it
// completes (or times out) and presents aligned/extended load data.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   MemReadM, MemWriteM        load / store in MEM (both high => store)
//   MemSizeM, MemSignedM       access size, sign-extend sub-word loads
//   ALUOutM, WriteDataM        byte address, right-justified store data
//   ReadDataM                  load result, non-zero only in DONE
//   StallM                     hold IF..MEM, bubble MEM/WB
//   AdErrM                     misaligned access (combinational)
//   BusErrM                    access timed out (DONE cycle only)
//   mem_req/we/addr/be/wdata   registered bus request
//   mem_ack, mem_rdata         bus completion pulse and read data
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16  // 1..255 BUSY cycles before bus error
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  MemSizeM,
    input  logic        MemSignedM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        AdErrM,
    output logic        BusErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    memState_t   state;
    logic [7:0]  cnt;
    logic [31:0] rdataQ;
    logic        errQ;
    loadCtx_t    ctxQ;

    logic        acc, mis, start;
    logic [1:0]  lane;
    logic [3:0]  beNext;
    logic [31:0] wdNext;
    logic [31:0] alignData;

    assign lane  = ALUOutM[1:0];
    assign acc   = MemReadM | MemWriteM;
    // MemSizeM[1] covers both word and the illegal code 3.
    assign mis   = ((MemSizeM == MEM_HALF) & lane[0]) | (MemSizeM[1] & (|lane));
    assign start = acc & ~mis;

    assign AdErrM  = acc & mis;
    // While reset is held the stage never stalls, even with an access pending.
    assign StallM  = rst_n & (((state == IDLE) & start) | (state == BUSY));
    assign BusErrM = (state == DONE) & errQ;

    // Store lane steering: replicate data across lanes, enable only the target bytes.
    always_comb begin
        case (MemSizeM)
            MEM_BYTE: begin
                beNext = 4'b0001 << lane;
                wdNext = {4{WriteDataM[7:0]}};
            end
            MEM_HALF: begin
                beNext = 4'b0011 << lane;
                wdNext = {2{WriteDataM[15:0]}};
            end
            default: begin
                beNext = 4'hF;
                wdNext = WriteDataM;
            end
        endcase
    end

    mem_load_align uAlign (
        .word   (rdataQ),
        .lane   (ctxQ.lane),
        .size   (ctxQ.size),
        .sgn    (ctxQ.sgn),
        .result (alignData)
    );

    assign ReadDataM = ((state == DONE) & ~mem_we & ~errQ) ? alignData : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            rdataQ    <= 32'd0;
            cnt       <= 8'd0;
            errQ      <= 1'b0;
            ctxQ      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 8'd0;
                    if (start) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWriteM;
                        mem_addr  <= {ALUOutM[31:2], 2'b00};
                        mem_be    <= beNext;
                        mem_wdata <= wdNext;
                        ctxQ      <= '{lane: lane, size: MemSizeM, sgn: MemSignedM};
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack in the final allowed cycle still wins over the timeout.
                    if (mem_ack) begin
                        rdataQ  <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        errQ    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    // Always pass through IDLE so the next instruction is decoded fresh.
                    errQ  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemReadM, MemWriteM, MemSignedM;
    logic [1:0]  MemSizeM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, AdErrM, BusErrM;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int total = 0;
    int bad   = 0;

    // Results of the last doAccess run.
    int          sCnt, rCnt;
    logic        finished, stable, errOut, adOut;
    logic [31:0] rdOut, aAddr, aWd;
    logic [3:0]  aBe;
    logic        aWe;

    mem_access_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemSizeM(MemSizeM),
        .MemSignedM(MemSignedM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .AdErrM(AdErrM), .BusErrM(BusErrM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge. Presents one access, plays a bus slave that acks
    // in BUSY cycle waits+1 (never if waits<0), and stops at the first
    // non-stalled cycle, recording the DONE-cycle outputs.
    task automatic doAccess(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                            input int waits, input logic [31:0] rdat);
        sCnt = 0; rCnt = 0; finished = 1'b0; stable = 1'b1;
        MemReadM = rd; MemWriteM = wr; MemSizeM = sz; MemSignedM = sg;
        ALUOutM = addr; WriteDataM = wd; mem_rdata = rdat; mem_ack = 1'b0;
        for (int k = 0; k < 40 && !finished; k++) begin
            #1;
            if (mem_req) begin
                if (rCnt == 0) begin
                    aAddr = mem_addr; aBe = mem_be; aWd = mem_wdata; aWe = mem_we;
                end else if ({mem_addr, mem_be, mem_wdata, mem_we} !== {aAddr, aBe, aWd, aWe}) begin
                    stable = 1'b0;
                end
                rCnt++;
            end
            mem_ack = mem_req && waits >= 0 && rCnt == waits + 1;
            if (StallM) sCnt++;
            else begin
                rdOut = ReadDataM; errOut = BusErrM; adOut = AdErrM; finished = 1'b1;
            end
            if (!finished) @(negedge clk);
        end
        MemReadM = 1'b0; MemWriteM = 1'b0; mem_ack = 1'b0;
        chk("access_finished", 32'(finished), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; MemReadM = 0; MemWriteM = 0; MemSizeM = 0; MemSignedM = 0;
        ALUOutM = 0; WriteDataM = 0; mem_ack = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",   32'(mem_req), 0);
        chk("rst_we",    32'(mem_we), 0);
        chk("rst_addr",  mem_addr, 0);
        chk("rst_be",    32'(mem_be), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", ReadDataM, 0);
        chk("rst_stall", 32'(StallM), 0);
        chk("rst_buserr", 32'(BusErrM), 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Aligned word load, zero-wait bus.
        doAccess(1, 0, 2'd2, 0, 32'h100, 0, 0, 32'hDEADBEEF);
        chk("wl_stall", sCnt, 2);
        chk("wl_req",   rCnt, 1);
        chk("wl_addr",  aAddr, 32'h100);
        chk("wl_be",    32'(aBe), 32'hF);
        chk("wl_we",    32'(aWe), 0);
        chk("wl_data",  rdOut, 32'hDEADBEEF);
        chk("wl_err",   32'(errOut), 0);
        @(negedge clk); #1;
        chk("wl_idle_data",  ReadDataM, 0);
        chk("wl_idle_stall", 32'(StallM), 0);

        // Signed then unsigned byte load from the top lane.
        doAccess(1, 0, 2'd0, 1, 32'h203, 0, 0, 32'h80123456);
        chk("sb_data", rdOut, 32'hFFFFFF80);
        chk("sb_addr", aAddr, 32'h200);
        chk("sb_be",   32'(aBe), 32'b1000);
        @(negedge clk);
        doAccess(1, 0, 2'd0, 0, 32'h203, 0, 0, 32'h80123456);
        chk("ub_data", rdOut, 32'h00000080);
        @(negedge clk);

        // Signed half load, upper half.
        doAccess(1, 0, 2'd1, 1, 32'h602, 0, 1, 32'h80017FFF);
        chk("sh_data",  rdOut, 32'hFFFF8001);
        chk("sh_stall", sCnt, 3);
        @(negedge clk);

        // Half store with three wait cycles.
        doAccess(0, 1, 2'd1, 0, 32'h302, 32'h0000ABCD, 3, 32'h11111111);
        chk("hs_we",     32'(aWe), 1);
        chk("hs_be",     32'(aBe), 32'b1100);
        chk("hs_wdata",  aWd, 32'hABCDABCD);
        chk("hs_addr",   aAddr, 32'h300);
        chk("hs_stable", 32'(stable), 1);
        chk("hs_req",    rCnt, 4);
        chk("hs_stall",  sCnt, 5);
        chk("hs_rdata",  rdOut, 0);
        @(negedge clk);

        // Byte store at lane 1.
        doAccess(0, 1, 2'd0, 0, 32'h501, 32'h123456A5, 0, 0);
        chk("bs_be",    32'(aBe), 32'b0010);
        chk("bs_wdata", aWd, 32'hA5A5A5A5);
        @(negedge clk);

        // Read and write together: the write wins.
        doAccess(1, 1, 2'd2, 0, 32'h700, 32'hCAFEF00D, 0, 32'h55555555);
        chk("rw_we",    32'(aWe), 1);
        chk("rw_wdata", aWd, 32'hCAFEF00D);
        chk("rw_rdata", rdOut, 0);
        @(negedge clk);

        // Misaligned word load: no bus cycle over several clocks.
        MemReadM = 1; MemSizeM = 2'd2; ALUOutM = 32'h102; mem_rdata = 32'hFFFFFFFF;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mis_aderr", 32'(AdErrM), 1);
            chk("mis_stall", 32'(StallM), 0);
            chk("mis_req",   32'(mem_req), 0);
            chk("mis_rdata", ReadDataM, 0);
            @(negedge clk);
        end
        MemSizeM = 2'd3; #1; chk("mis_size3", 32'(AdErrM), 1);
        MemSizeM = 2'd1; ALUOutM = 32'h101; #1; chk("mis_half", 32'(AdErrM), 1);
        MemSizeM = 2'd0; #1; chk("byte_odd_ok", 32'(AdErrM), 0);
        MemReadM = 0; #1; chk("noacc_aderr", 32'(AdErrM), 0);
        @(negedge clk); @(negedge clk);

        // No ack: timeout after 16 BUSY cycles, then a late ack is ignored.
        doAccess(1, 0, 2'd2, 0, 32'h800, 0, -1, 32'h12345678);
        chk("to_req",    rCnt, 16);
        chk("to_stall",  sCnt, 17);
        chk("to_buserr", 32'(errOut), 1);
        chk("to_rdata",  rdOut, 0);
        mem_ack = 1'b1;
        @(negedge clk); #1;
        chk("late_req",    32'(mem_req), 0);
        chk("late_stall",  32'(StallM), 0);
        chk("late_buserr", 32'(BusErrM), 0);
        chk("late_rdata",  ReadDataM, 0);
        @(negedge clk); mem_ack = 1'b0; #1;
        chk("late_req2", 32'(mem_req), 0);
        @(negedge clk);

        // Reset pulsed mid-access.
        MemReadM = 1; MemSizeM = 2'd2; ALUOutM = 32'h400;
        @(negedge clk); #1;
        chk("rb_req_before", 32'(mem_req), 1);
        rst_n = 1'b0; #1;
        chk("rb_req",    32'(mem_req), 0);
        chk("rb_stall",  32'(StallM), 0);
        chk("rb_buserr", 32'(BusErrM), 0);
        MemReadM = 0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rb_noretry", 32'(mem_req), 0);
        @(negedge clk);
        doAccess(1, 0, 2'd2, 0, 32'h104, 0, 1, 32'h12345678);
        chk("rb_next_data",  rdOut, 32'h12345678);
        chk("rb_next_stall", sCnt, 3);
        chk("rb_next_err",   32'(errOut), 0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
